// File: rtl/l1_meta_pkg.sv
// ============================================================================
// Module : l1_meta_pkg
// Brief  : Shared defaults, FSM state encoding and request/response bundles
//          for the L1 metadata (tag + valid) array.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package l1_meta_pkg;

    localparam int NSETS_DEF = 64;
    localparam int NWAYS_DEF = 4;
    localparam int TAGW_DEF  = 20;
    localparam int IDXW_DEF  = $clog2(NSETS_DEF);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } meta_state_e;

    typedef struct packed {
        logic [IDXW_DEF-1:0]  idx;
        logic [NWAYS_DEF-1:0] way_en;
        logic [TAGW_DEF-1:0]  tag;
        logic                 chosen;
    } meta_wreq_t;

    typedef struct packed {
        logic [NWAYS_DEF*TAGW_DEF-1:0] tags;
        logic [NWAYS_DEF-1:0]          vld;
    } meta_rresp_t;

endpackage

`default_nettype wire

// File: rtl/l1_meta_init_ctrl.sv
// ============================================================================
// Module : l1_meta_init_ctrl
// Brief  : Post-reset sequencer that walks every set once to clear it, then
//          enables the request ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l1_meta_init_ctrl
    import l1_meta_pkg::*;
#(
    parameter int NSETS = NSETS_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     run_o,
    output logic                     clr_en_o,
    output logic [$clog2(NSETS)-1:0] clr_idx_o
);

    localparam int IDXW = $clog2(NSETS);
    localparam logic [IDXW-1:0] C_LAST = IDXW'(NSETS - 1);

    meta_state_e     state_q;
    logic [IDXW-1:0] cnt_q;
    logic            run_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                    run_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign run_o     = run_q;
    assign clr_en_o  = ~run_q;
    assign clr_idx_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/l1_meta_array.sv
// ============================================================================
// Module : l1_meta_array
// Brief  : Flop-based L1 tag/valid array with one write and one read port,
//          write acknowledge and a registered read response.
//          Optional macro META_BYPASS_EN forwards a same-cycle write to a
//          same-index read for the written ways.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l1_meta_array
    import l1_meta_pkg::*;
#(
    parameter int NSETS = NSETS_DEF,
    parameter int NWAYS = NWAYS_DEF,
    parameter int TAGW  = TAGW_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     io_wreq_ready,
    input  logic                     io_wreq_valid,
    input  logic [$clog2(NSETS)-1:0] io_wreq_bits_idx,
    input  logic [NWAYS-1:0]         io_wreq_bits_way_en,
    input  logic [TAGW-1:0]          io_wreq_bits_tag,
    input  logic                     io_wreq_chosen,
    output logic                     io_wack_valid,
    output logic                     io_wack_src,
    output logic                     io_rreq_ready,
    input  logic                     io_rreq_valid,
    input  logic [$clog2(NSETS)-1:0] io_rreq_bits_idx,
    output logic                     io_rresp_valid,
    output logic [NWAYS*TAGW-1:0]    io_rresp_tags,
    output logic [NWAYS-1:0]         io_rresp_vld
);

    localparam int IDXW = $clog2(NSETS);

    logic [TAGW-1:0]  tag_q [NSETS][NWAYS];
    logic [NWAYS-1:0] vld_q [NSETS];

    logic             w_run;
    logic             w_clr_en;
    logic [IDXW-1:0]  w_clr_idx;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic [NWAYS*TAGW-1:0] w_rd_tags;
    logic [NWAYS-1:0]      w_rd_vld;

    logic                  wack_valid_q;
    logic                  wack_src_q;
    logic                  rresp_valid_q;
    logic [NWAYS*TAGW-1:0] rresp_tags_q;
    logic [NWAYS-1:0]      rresp_vld_q;

    l1_meta_init_ctrl #(
        .NSETS (NSETS)
    ) u_init_ctrl (
        .clock     (clock),
        .reset     (reset),
        .run_o     (w_run),
        .clr_en_o  (w_clr_en),
        .clr_idx_o (w_clr_idx)
    );

    assign io_wreq_ready = w_run;
    assign io_rreq_ready = w_run;
    assign w_wr_fire     = io_wreq_valid & w_run;
    assign w_rd_fire     = io_rreq_valid & w_run;

    // Storage carries no reset: the init walk clears every set before use.
    always_ff @(posedge clock) begin
        if (w_clr_en) begin
            vld_q[w_clr_idx] <= '0;
            for (int w = 0; w < NWAYS; w++) begin
                tag_q[w_clr_idx][w] <= '0;
            end
        end else if (w_wr_fire && !reset) begin
            for (int w = 0; w < NWAYS; w++) begin
                if (io_wreq_bits_way_en[w]) begin
                    tag_q[io_wreq_bits_idx][w] <= io_wreq_bits_tag;
                    vld_q[io_wreq_bits_idx][w] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_tags = '0;
        w_rd_vld  = vld_q[io_rreq_bits_idx];
        for (int w = 0; w < NWAYS; w++) begin
            w_rd_tags[w*TAGW +: TAGW] = tag_q[io_rreq_bits_idx][w];
`ifdef META_BYPASS_EN
            if (w_wr_fire && (io_wreq_bits_idx == io_rreq_bits_idx) && io_wreq_bits_way_en[w]) begin
                w_rd_tags[w*TAGW +: TAGW] = io_wreq_bits_tag;
                w_rd_vld[w]               = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wack_valid_q  <= 1'b0;
            wack_src_q    <= 1'b0;
            rresp_valid_q <= 1'b0;
            rresp_tags_q  <= '0;
            rresp_vld_q   <= '0;
        end else begin
            wack_valid_q  <= w_wr_fire;
            rresp_valid_q <= w_rd_fire;
            if (w_wr_fire) begin
                wack_src_q <= io_wreq_chosen;
            end
            if (w_rd_fire) begin
                rresp_tags_q <= w_rd_tags;
                rresp_vld_q  <= w_rd_vld;
            end
        end
    end

    assign io_wack_valid  = wack_valid_q;
    assign io_wack_src    = wack_src_q;
    assign io_rresp_valid = rresp_valid_q;
    assign io_rresp_tags  = rresp_tags_q;
    assign io_rresp_vld   = rresp_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_l1_meta_array.sv
// ============================================================================
// Module : tb_l1_meta_array
// Brief  : Vector-table bench for l1_meta_array with a response scoreboard;
//          expectations follow META_BYPASS_EN when it is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_l1_meta_array;
    import l1_meta_pkg::*;

    typedef struct packed {
        logic        wv;
        meta_wreq_t  w;
        logic        rv;
        logic [5:0]  ridx;
        meta_rresp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wreq_valid = 1'b0;
    logic [5:0]  wreq_idx = '0;
    logic [3:0]  wreq_way_en = '0;
    logic [19:0] wreq_tag = '0;
    logic        wreq_chosen = 1'b0;
    logic        rreq_valid = 1'b0;
    logic [5:0]  rreq_idx = '0;
    logic        wreq_ready, rreq_ready, wack_valid, wack_src, rresp_valid;
    logic [79:0] rresp_tags;
    logic [3:0]  rresp_vld;

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;
    bit run_exp = 1'b0;
    logic        wq[$];
    meta_rresp_t rq[$];
    meta_rresp_t last_e = '0;

    l1_meta_array dut (
        .clock               (clk),
        .reset               (reset),
        .io_wreq_ready       (wreq_ready),
        .io_wreq_valid       (wreq_valid),
        .io_wreq_bits_idx    (wreq_idx),
        .io_wreq_bits_way_en (wreq_way_en),
        .io_wreq_bits_tag    (wreq_tag),
        .io_wreq_chosen      (wreq_chosen),
        .io_wack_valid       (wack_valid),
        .io_wack_src         (wack_src),
        .io_rreq_ready       (rreq_ready),
        .io_rreq_valid       (rreq_valid),
        .io_rreq_bits_idx    (rreq_idx),
        .io_rresp_valid      (rresp_valid),
        .io_rresp_tags       (rresp_tags),
        .io_rresp_vld        (rresp_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [83:0] act, input logic [83:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mkv(input logic wv, input logic [5:0] widx, input logic [3:0] wen,
                                 input logic [19:0] wtag, input logic wch, input logic rv,
                                 input logic [5:0] ridx, input logic [3:0] ev, input logic [79:0] et);
        vec_t v;
        v.wv = wv; v.w.idx = widx; v.w.way_en = wen; v.w.tag = wtag; v.w.chosen = wch;
        v.rv = rv; v.ridx = ridx; v.e.tags = et; v.e.vld = ev;
        return v;
    endfunction

    // One cycle of stimulus; expected responses are queued at the edge that accepts them.
    task automatic drive(input vec_t v);
        wreq_valid = v.wv; wreq_idx = v.w.idx; wreq_way_en = v.w.way_en;
        wreq_tag = v.w.tag; wreq_chosen = v.w.chosen;
        rreq_valid = v.rv; rreq_idx = v.ridx;
        @(posedge clk);
        if (reset) begin
            wq.delete(); rq.delete(); last_e = '0;
        end else if (run_exp) begin
            if (v.wv) wq.push_back(v.w.chosen);
            if (v.rv) rq.push_back(v.e);
        end
        #1;
        wreq_valid = 1'b0; rreq_valid = 1'b0;
    endtask

    task automatic wait_init();
        int n = 0;
        run_exp = 1'b0;
        while (wreq_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk(n == 64 && rreq_ready === 1'b1, "init_cycles", 84'(n), 84'(64));
        run_exp = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (wq.size() > 0) begin
                logic e;
                e = wq.pop_front();
                chk(wack_valid === 1'b1 && wack_src === e, "wack", 84'({wack_valid, wack_src}), 84'({1'b1, e}));
            end else begin
                chk(wack_valid === 1'b0, "wack_idle", 84'(wack_valid), 84'(0));
            end
            if (rq.size() > 0) begin
                last_e = rq.pop_front();
                chk(rresp_valid === 1'b1 && rresp_tags === last_e.tags && rresp_vld === last_e.vld,
                    "rresp", {rresp_valid, rresp_tags, rresp_vld[2:0]}, {1'b1, last_e.tags, last_e.vld[2:0]});
                if (rresp_vld[3] !== last_e.vld[3]) chk(1'b0, "rresp_vld3", 84'(rresp_vld), 84'(last_e.vld));
            end else begin
                chk(rresp_valid === 1'b0 && rresp_tags === last_e.tags && rresp_vld === last_e.vld,
                    "rresp_hold", {rresp_tags, rresp_vld}, {last_e.tags, last_e.vld});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam int NV = 14;
    vec_t vec [NV];
    vec_t idle;

    initial begin
        idle = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec[0]  = mkv(0, 0, 4'b0000, 20'h0, 0, 1, 5, 4'b0000, 80'h0);
        vec[1]  = mkv(1, 3, 4'b0100, 20'hABCDE, 1, 0, 0, 4'b0000, 80'h0);
        vec[2]  = mkv(0, 0, 4'b0000, 20'h0, 0, 1, 3, 4'b0100, {20'h0, 20'hABCDE, 20'h0, 20'h0});
`ifdef META_BYPASS_EN
        vec[3]  = mkv(1, 7, 4'b0001, 20'h12345, 0, 1, 7, 4'b0001, {60'h0, 20'h12345});
        vec[10] = mkv(1, 3, 4'b0001, 20'h11111, 1, 1, 3, 4'b0101, {20'h0, 20'hABCDE, 20'h0, 20'h11111});
`else
        vec[3]  = mkv(1, 7, 4'b0001, 20'h12345, 0, 1, 7, 4'b0000, 80'h0);
        vec[10] = mkv(1, 3, 4'b0001, 20'h11111, 1, 1, 3, 4'b0100, {20'h0, 20'hABCDE, 20'h0, 20'h0});
`endif
        vec[4]  = mkv(0, 0, 4'b0000, 20'h0, 0, 1, 7, 4'b0001, {60'h0, 20'h12345});
        vec[5]  = mkv(1, 9, 4'b0000, 20'h77777, 1, 0, 0, 4'b0000, 80'h0);
        vec[6]  = mkv(0, 0, 4'b0000, 20'h0, 0, 1, 9, 4'b0000, 80'h0);
        vec[7]  = mkv(1, 63, 4'b1111, 20'hFFFFF, 0, 1, 3, 4'b0100, {20'h0, 20'hABCDE, 20'h0, 20'h0});
        vec[8]  = mkv(0, 0, 4'b0000, 20'h0, 0, 1, 63, 4'b1111, {4{20'hFFFFF}});
        vec[9]  = mkv(0, 0, 4'b0000, 20'h0, 0, 1, 0, 4'b0000, 80'h0);
        vec[11] = mkv(0, 0, 4'b0000, 20'h0, 0, 1, 3, 4'b0101, {20'h0, 20'hABCDE, 20'h0, 20'h11111});
        vec[12] = mkv(1, 3, 4'b0100, 20'h22222, 0, 1, 63, 4'b1111, {4{20'hFFFFF}});
        vec[13] = mkv(0, 0, 4'b0000, 20'h0, 0, 1, 3, 4'b0101, {20'h0, 20'h22222, 20'h0, 20'h11111});

        reset = 1'b1;
        drive(idle);
        mon_en = 1'b1;
        chk(wack_valid === 0 && wack_src === 0 && rresp_valid === 0 && rresp_tags === 0 &&
            rresp_vld === 0 && wreq_ready === 0 && rreq_ready === 0, "reset_outputs",
            {wack_valid, wack_src, rresp_valid, rresp_tags, rresp_vld[2:0]}, 84'(0));
        reset = 1'b0;
        wait_init();

        for (int i = 0; i < NV; i++) drive(vec[i]);
        drive(idle);
        drive(idle);

        // Write stream interrupted by reset on the 31st write.
        for (int i = 0; i < 64; i++) begin
            if (i == 30) reset = 1'b1;
            drive(mkv(1, 6'(i), 4'b1111, 20'(i + 1), i[0], 0, 0, 0, 0));
            if (i == 30) break;
        end
        chk(wreq_ready === 0 && rreq_ready === 0, "ready_after_reset", 84'({wreq_ready, rreq_ready}), 84'(0));
        reset = 1'b0;
        wait_init();
        for (int s = 0; s < 64; s++) drive(mkv(0, 0, 0, 0, 0, 1, 6'(s), 4'b0000, 80'h0));
        drive(idle);
        drive(idle);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/l1_meta_array.md
L1_META_ARRAY -- requirements
Module: l1_meta_array

Interface
REQ-001 SHALL have parameter NSETS, default 64, the number of sets; the index width is log2(NSETS).
REQ-002 SHALL have parameter NWAYS, default 4, the number of ways.
REQ-003 SHALL have parameter TAGW, default 20, the tag width.
REQ-004 SHALL use one clock and a synchronous, active-high reset; clock and reset are listed first:
- clock  in  1  sole clock
- reset  in  1  synchronous active-high reset
REQ-005 SHALL provide the write request port:
- io_wreq_ready  out  1  write accepted this cycle
- io_wreq_valid  in  1  write request
- io_wreq_bits_idx  in  6  target set
- io_wreq_bits_way_en  in  4  one-hot/multi-hot way mask
- io_wreq_bits_tag  in  20  tag to store
- io_wreq_chosen  in  1  source id from upstream arbiter
REQ-006 SHALL provide the write acknowledge:
- io_wack_valid  out  1  write committed
- io_wack_src  out  1  echoed io_wreq_chosen
REQ-007 SHALL provide the read port:
- io_rreq_ready  out  1  read accepted
- io_rreq_valid  in  1  read request
- io_rreq_bits_idx  in  6  set to read
- io_rresp_valid  out  1  read data valid
- io_rresp_tags  out  80  way w tag at bits [w*20 +: 20]
- io_rresp_vld  out  4  per-way valid bits

Function
REQ-008 SHALL hold per set and per way one TAGW-bit tag and one valid bit in flops.
REQ-009 SHALL implement an FSM with states INIT and RUN; reset forces INIT with the clear counter at 0.
REQ-010 In INIT, SHALL clear the tags and valid bits of set[counter] each cycle, increment the counter, and move to RUN after set NSETS-1 is cleared (NSETS cycles).
REQ-011 In INIT, io_wreq_ready=0 and io_rreq_ready=0; in RUN, both SHALL be 1.
REQ-012 A write is accepted when io_wreq_valid & io_wreq_ready; on the next clock edge, for each way w with way_en[w]=1, SHALL set tag=io_wreq_bits_tag and valid=1.
REQ-013 way_en=0 SHALL modify no state but is still accepted and acknowledged.
REQ-014 io_wack_valid SHALL pulse exactly one cycle after each accepted write, with io_wack_src equal to the accepted chosen bit.
REQ-015 A read is accepted when io_rreq_valid & io_rreq_ready; io_rresp_valid, io_rresp_tags and io_rresp_vld SHALL be registered and present exactly one cycle later.
REQ-016 io_rresp_tags and io_rresp_vld SHALL hold their last value while io_rresp_valid=0.
REQ-017 A read and a write in the same cycle SHALL both be accepted; the read/write interaction for the same idx is set by REQ-021/REQ-022.
REQ-018 Back-to-back reads and writes every cycle SHALL be sustained with no bubbles.

Reset
REQ-019 In the cycle after reset is asserted, SHALL drive: io_wack_valid=0, io_wack_src=0, io_rresp_valid=0, io_rresp_tags=0, io_rresp_vld=0, both readies=0.
REQ-020 Reset asserted mid-INIT or mid-RUN SHALL drop any pending response or ack and restart INIT from counter 0.

Configuration
REQ-021 With META_BYPASS_EN defined, a same-cycle write and read to the same idx SHALL return the newly written tag and valid=1 for written ways, and the old contents for the other ways.
REQ-022 Without META_BYPASS_EN, the same case SHALL return the pre-write contents for all ways.

Structure
REQ-023 SHALL place NSETS/NWAYS/TAGW defaults, the FSM state enum and the wreq/rresp bundle typedefs in the shared package l1_meta_pkg.
REQ-024 SHALL put the init sequencer (FSM plus clear counter) in one sub-module, l1_meta_init_ctrl; the storage, ports and bypass stay in the top.

Verification
REQ-025 Reset, then release -> readies 0 for exactly 64 cycles, 1 on cycle 65; a read of idx 5 returns vld=4'b0000 and tags=0.
REQ-026 Write idx=3, way_en=4'b0100, tag=20'hABCDE, chosen=1 -> wack_valid for 1 cycle with src=1; a later read of idx 3 returns vld=4'b0100 and tags[59:40]=20'hABCDE.
REQ-027 Same-cycle write idx 7, way_en=4'b0001, tag=20'h12345 and read idx 7 -> with META_BYPASS_EN, vld[0]=1 and tags[19:0]=20'h12345; without it, vld[0]=0.
REQ-028 Write way_en=0 to idx 9 -> wack pulses; a read of idx 9 is unchanged (vld=0).
REQ-029 Stream of 64 writes to idx 0..63, then reset asserted at write 30 -> no wack after reset, INIT restarts, and all sets read vld=0 afterward.
REQ-030 Write idx 63, way_en=4'b1111, tag=20'hFFFFF -> a read of idx 63 returns vld=4'b1111 with all tags 20'hFFFFF; idx 0 is unaffected.
